// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Pipelined integer ALU functional unit between the ALU issue queue and the
// common writeback arbiter. S0 registers the issued operands, the result is
// computed combinationally from S0 and registered into S1, and S1..S(LAT-1)
// carry the result to the writeback outputs driven from S(LAT-1).
//
// Stalls collapse bubbles: a writeback stall only holds stages that are full,
// so empty slots further down still fill. Ops younger than a squash boundary
// (by ROB age with wrap bit) are killed wherever they sit, including the op on
// the issue port in the squash cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_vld / o_fu_stall  issue handshake; a stalled op must be held by issue
//   i_op, i_src0/1      operation and operands
//   i_rob_idx, i_prd,   ROB index (with wrap bit), destination register,
//   i_rdwen             register write enable
//   i_squash(_rob)      kill all in-flight ops strictly younger than boundary
//   o_willwrite_*       early bypass from S1 (valid only if rdwen)
//   i_wb_stall          writeback cannot accept the last-stage op
//   o_fu_finished,      last-stage valid and payload
//   o_wb_*
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int XLEN = 64,
    parameter int LAT  = 2,
    parameter int ROBW = 7,
    parameter int PRDW = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_vld,
    output logic            o_fu_stall,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_src0,
    input  logic [XLEN-1:0] i_src1,
    input  logic [ROBW-1:0] i_rob_idx,
    input  logic [PRDW-1:0] i_prd,
    input  logic            i_rdwen,
    input  logic            i_squash,
    input  logic [ROBW-1:0] i_squash_rob,
    output logic            o_willwrite_vld,
    output logic [PRDW-1:0] o_willwrite_prd,
    output logic [XLEN-1:0] o_willwrite_data,
    input  logic            i_wb_stall,
    output logic            o_fu_finished,
    output logic [ROBW-1:0] o_wb_rob,
    output logic [PRDW-1:0] o_wb_prd,
    output logic            o_wb_rdwen,
    output logic [XLEN-1:0] o_wb_data
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_ADDW = 4'd10;

    // Per-stage control and payload
    logic [LAT-1:0]  vld_q, vld_d;
    logic [LAT-1:0]  rdwen_q, rdwen_d;
    logic [ROBW-1:0] rob_q [LAT];
    logic [ROBW-1:0] rob_d [LAT];
    logic [PRDW-1:0] prd_q [LAT];
    logic [PRDW-1:0] prd_d [LAT];
    // Results exist only from S1 onwards
    logic [XLEN-1:0] res_q [1:LAT-1];
    logic [XLEN-1:0] res_d [1:LAT-1];
    // S0 operand payload
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] src0_q, src0_d;
    logic [XLEN-1:0] src1_q, src1_d;

    logic [LAT-1:0]  adv;
    logic [LAT-1:0]  load;
    logic [LAT-1:0]  kill;
    logic            kill_in;
    logic [XLEN-1:0] alu_res;

    // e is younger than b: same wrap phase compares directly, opposite phase
    // means e has wrapped past b's half, so the ordering flips.
    function automatic logic younger(input logic [ROBW-1:0] e, input logic [ROBW-1:0] b);
        if (e[ROBW-1] == b[ROBW-1]) begin
            return e[ROBW-2:0] > b[ROBW-2:0];
        end
        return e[ROBW-2:0] < b[ROBW-2:0];
    endfunction

    assign kill_in = i_squash && younger(i_rob_idx, i_squash_rob);

    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        assign kill[gi] = i_squash && younger(rob_q[gi], i_squash_rob);
        // An empty stage can always take whatever its upstream offers; this
        // is what lets bubbles collapse behind a stalled writeback.
        assign load[gi] = adv[gi] || !vld_q[gi];
    end

    // Advance chain from the writeback end back to S0. Uses registered valid
    // bits only, so a slot freed by a squash opens up on the following cycle.
    always_comb begin
        adv = '0;
        adv[LAT-1] = !i_wb_stall;
        for (int k = LAT - 2; k >= 0; k--) begin
            adv[k] = !vld_q[k+1] || adv[k+1];
        end
    end

    assign o_fu_stall = vld_q[0] && !adv[0];

    // Execute, from the S0 operands
    always_comb begin
        logic [SHW-1:0]  shamt;
        logic [XLEN-1:0] sum;
        shamt   = src1_q[SHW-1:0];
        sum     = src0_q + src1_q;
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = src0_q - src1_q;
            OP_AND:  alu_res = src0_q & src1_q;
            OP_OR:   alu_res = src0_q | src1_q;
            OP_XOR:  alu_res = src0_q ^ src1_q;
            OP_SLL:  alu_res = src0_q << shamt;
            OP_SRL:  alu_res = src0_q >> shamt;
            OP_SRA:  alu_res = $signed(src0_q) >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src0_q) < $signed(src1_q)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src0_q < src1_q};
            // Low-word sum sign-extended; degenerates to ADD when XLEN is 32
            OP_ADDW: alu_res = XLEN'(signed'(sum[31:0]));
            default: alu_res = '0;
        endcase
    end

    // Stage movement. A holding stage still drops a killed op; a loading
    // stage inherits the kill of the op it takes from upstream.
    always_comb begin
        vld_d   = vld_q;
        rdwen_d = rdwen_q;
        rob_d   = rob_q;
        prd_d   = prd_q;
        res_d   = res_q;
        op_d    = op_q;
        src0_d  = src0_q;
        src1_d  = src1_q;

        if (load[0]) begin
            vld_d[0]   = i_vld && !kill_in;
            rdwen_d[0] = i_rdwen;
            rob_d[0]   = i_rob_idx;
            prd_d[0]   = i_prd;
            op_d       = i_op;
            src0_d     = i_src0;
            src1_d     = i_src1;
        end else begin
            vld_d[0] = vld_q[0] && !kill[0];
        end

        for (int k = 1; k < LAT; k++) begin
            if (load[k]) begin
                vld_d[k]   = vld_q[k-1] && !kill[k-1];
                rdwen_d[k] = rdwen_q[k-1];
                rob_d[k]   = rob_q[k-1];
                prd_d[k]   = prd_q[k-1];
            end else begin
                vld_d[k] = vld_q[k] && !kill[k];
            end
        end

        if (load[1]) begin
            res_d[1] = alu_res;
        end
        for (int k = 2; k < LAT; k++) begin
            if (load[k]) begin
                res_d[k] = res_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
        rdwen_q <= rdwen_d;
        rob_q   <= rob_d;
        prd_q   <= prd_d;
        res_q   <= res_d;
        op_q    <= op_d;
        src0_q  <= src0_d;
        src1_q  <= src1_d;
    end

    // Early bypass must disappear in the very cycle S1 is squashed
    assign o_willwrite_vld  = vld_q[1] && rdwen_q[1] && !kill[1];
    assign o_willwrite_prd  = prd_q[1];
    assign o_willwrite_data = res_q[1];

    assign o_fu_finished = vld_q[LAT-1];
    assign o_wb_rob      = rob_q[LAT-1];
    assign o_wb_prd      = prd_q[LAT-1];
    assign o_wb_rdwen    = rdwen_q[LAT-1];
    assign o_wb_data     = res_q[LAT-1];

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
//
// Two units side by side: unit 0 with LAT=2, unit 1 with LAT=4 (both XLEN=64).
// A monitor on the falling edge pushes an expected result for every op the
// unit accepts and pops/compares on every consumed finish; directed sequences
// add explicit latency, stall, bypass, squash and reset checks.
// ---------------------------------------------------------------------------
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        vld_in [2];
    logic [3:0]  op_in  [2];
    logic [63:0] a_in   [2];
    logic [63:0] b_in   [2];
    logic [6:0]  rob_in [2];
    logic [6:0]  prd_in [2];
    logic        wen_in [2];
    logic        sq     [2];
    logic [6:0]  sqrob  [2];
    logic        wbst   [2];

    logic        stall_o [2];
    logic        wwv     [2];
    logic [6:0]  wwprd   [2];
    logic [63:0] wwdata  [2];
    logic        fin_o   [2];
    logic [6:0]  wbrob   [2];
    logic [6:0]  wbprd   [2];
    logic        wbwen   [2];
    logic [63:0] wbdata  [2];

    alu_pipe #(.XLEN(64), .LAT(2), .ROBW(7), .PRDW(7)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .i_vld(vld_in[0]), .o_fu_stall(stall_o[0]), .i_op(op_in[0]),
        .i_src0(a_in[0]), .i_src1(b_in[0]), .i_rob_idx(rob_in[0]),
        .i_prd(prd_in[0]), .i_rdwen(wen_in[0]),
        .i_squash(sq[0]), .i_squash_rob(sqrob[0]),
        .o_willwrite_vld(wwv[0]), .o_willwrite_prd(wwprd[0]), .o_willwrite_data(wwdata[0]),
        .i_wb_stall(wbst[0]), .o_fu_finished(fin_o[0]), .o_wb_rob(wbrob[0]),
        .o_wb_prd(wbprd[0]), .o_wb_rdwen(wbwen[0]), .o_wb_data(wbdata[0])
    );

    alu_pipe #(.XLEN(64), .LAT(4), .ROBW(7), .PRDW(7)) u_dut_l4 (
        .clk(clk), .rst(rst),
        .i_vld(vld_in[1]), .o_fu_stall(stall_o[1]), .i_op(op_in[1]),
        .i_src0(a_in[1]), .i_src1(b_in[1]), .i_rob_idx(rob_in[1]),
        .i_prd(prd_in[1]), .i_rdwen(wen_in[1]),
        .i_squash(sq[1]), .i_squash_rob(sqrob[1]),
        .o_willwrite_vld(wwv[1]), .o_willwrite_prd(wwprd[1]), .o_willwrite_data(wwdata[1]),
        .i_wb_stall(wbst[1]), .o_fu_finished(fin_o[1]), .o_wb_rob(wbrob[1]),
        .o_wb_prd(wbprd[1]), .o_wb_rdwen(wbwen[1]), .o_wb_data(wbdata[1])
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference ALU
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0] s;
        logic [5:0]  sh;
        sh = b[5:0];
        s  = a + b;
        case (op)
            4'd0:    return s;
            4'd1:    return a + ~b + 64'd1;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return 64'($signed(a) >>> sh);
            4'd8:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9:    return (a < b) ? 64'd1 : 64'd0;
            4'd10:   return {{32{s[31]}}, s[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_younger(input logic [6:0] e, input logic [6:0] b);
        logic [5:0] el;
        logic [5:0] bl;
        el = e[5:0];
        bl = b[5:0];
        if (e[6] ^ b[6]) return el < bl;
        return el > bl;
    endfunction

    typedef struct {
        int          unit;
        logic [6:0]  rob;
        logic [6:0]  prd;
        logic        wen;
        logic [63:0] data;
    } exp_t;

    exp_t sbq[$];
    int   mon_idx;

    // Scoreboard: evaluated mid-cycle for what the next rising edge will do
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            mon_idx = -1;
            for (int i = 0; i < sbq.size(); i++) begin
                if (mon_idx < 0 && sbq[i].unit == u) mon_idx = i;
            end
            if (rst) begin
                for (int i = sbq.size() - 1; i >= 0; i--) begin
                    if (sbq[i].unit == u) sbq.delete(i);
                end
            end else begin
                if (mon_idx < 0) begin
                    check($sformatf("u%0d_idle_fin", u), 64'(fin_o[u]), 64'd0);
                end else if (fin_o[u] && !wbst[u]) begin
                    $display("unit%0d finish rob=%h prd=%h wen=%0d data=%h",
                             u, wbrob[u], wbprd[u], wbwen[u], wbdata[u]);
                    check($sformatf("u%0d_wb_rob", u), 64'(wbrob[u]), 64'(sbq[mon_idx].rob));
                    check($sformatf("u%0d_wb_prd", u), 64'(wbprd[u]), 64'(sbq[mon_idx].prd));
                    check($sformatf("u%0d_wb_wen", u), 64'(wbwen[u]), 64'(sbq[mon_idx].wen));
                    check($sformatf("u%0d_wb_data", u), wbdata[u], sbq[mon_idx].data);
                    sbq.delete(mon_idx);
                end
                if (sq[u]) begin
                    for (int i = sbq.size() - 1; i >= 0; i--) begin
                        if (sbq[i].unit == u && ref_younger(sbq[i].rob, sqrob[u])) sbq.delete(i);
                    end
                end
                if (vld_in[u] && !stall_o[u] && !(sq[u] && ref_younger(rob_in[u], sqrob[u]))) begin
                    sbq.push_back('{u, rob_in[u], prd_in[u], wen_in[u],
                                    ref_alu(op_in[u], a_in[u], b_in[u])});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int u, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [6:0] rob, input logic [6:0] prd,
                       input logic wen);
        vld_in[u] = 1'b1;
        op_in[u]  = op;
        a_in[u]   = a;
        b_in[u]   = b;
        rob_in[u] = rob;
        prd_in[u] = prd;
        wen_in[u] = wen;
    endtask

    task automatic idle(input int u);
        vld_in[u] = 1'b0;
    endtask

    logic [3:0]  t_op [12];
    logic [63:0] t_a  [12];
    logic [63:0] t_b  [12];

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            vld_in[u] = 1'b0; op_in[u] = 4'd0; a_in[u] = '0; b_in[u] = '0;
            rob_in[u] = '0; prd_in[u] = '0; wen_in[u] = 1'b0;
            sq[u] = 1'b0; sqrob[u] = '0; wbst[u] = 1'b0;
        end

        t_op[0]  = 4'd1;  t_a[0]  = 64'd0;                  t_b[0]  = 64'd1;
        t_op[1]  = 4'd7;  t_a[1]  = 64'h8000_0000_0000_0000; t_b[1]  = 64'd63;
        t_op[2]  = 4'd9;  t_a[2]  = 64'd1;                  t_b[2]  = 64'd3;
        t_op[3]  = 4'd10; t_a[3]  = 64'h7FFF_FFFF;          t_b[3]  = 64'd1;
        t_op[4]  = 4'd2;  t_a[4]  = 64'hF0F0;               t_b[4]  = 64'hFF00;
        t_op[5]  = 4'd3;  t_a[5]  = 64'hF0F0;               t_b[5]  = 64'h0F0F;
        t_op[6]  = 4'd4;  t_a[6]  = 64'hFFFF;               t_b[6]  = 64'h00FF;
        t_op[7]  = 4'd5;  t_a[7]  = 64'd1;                  t_b[7]  = 64'd68;
        t_op[8]  = 4'd6;  t_a[8]  = 64'h8000_0000_0000_0000; t_b[8]  = 64'd63;
        t_op[9]  = 4'd8;  t_a[9]  = '1;                     t_b[9]  = 64'd1;
        t_op[10] = 4'd9;  t_a[10] = '1;                     t_b[10] = 64'd1;
        t_op[11] = 4'd13; t_a[11] = 64'd5;                  t_b[11] = 64'd7;

        // Reset state
        step();
        step();
        for (int u = 0; u < 2; u++) begin
            check("rst_fin", 64'(fin_o[u]), 64'd0);
            check("rst_stall", 64'(stall_o[u]), 64'd0);
            check("rst_wwv", 64'(wwv[u]), 64'd0);
        end
        rst = 1'b0;
        step();

        // Single ADD, latency and bypass timing on both depths
        put(0, 4'd0, 64'd5, 64'd7, 7'h01, 7'h11, 1'b1);
        put(1, 4'd0, 64'd5, 64'd7, 7'h01, 7'h21, 1'b1);
        step();
        idle(0);
        idle(1);
        check("t1_u0_fin_early", 64'(fin_o[0]), 64'd0);
        step();
        check("t1_u0_fin", 64'(fin_o[0]), 64'd1);
        check("t1_u0_data", wbdata[0], 64'd12);
        check("t1_u0_wwv", 64'(wwv[0]), 64'd1);
        check("t1_u0_wwdata", wwdata[0], 64'd12);
        check("t1_u0_wwprd", 64'(wwprd[0]), 64'h11);
        check("t1_u1_wwv", 64'(wwv[1]), 64'd1);
        check("t1_u1_wwdata", wwdata[1], 64'd12);
        check("t1_u1_fin_early", 64'(fin_o[1]), 64'd0);
        step();
        step();
        check("t1_u1_fin", 64'(fin_o[1]), 64'd1);
        check("t1_u1_data", wbdata[1], 64'd12);
        step();

        // Back-to-back ops, one finish per cycle
        for (int i = 0; i < 12; i++) begin
            put(0, t_op[i], t_a[i], t_b[i], 7'(8'h10 + i), 7'(i), (i % 3) != 0);
            put(1, t_op[i], t_a[i], t_b[i], 7'(8'h10 + i), 7'(i), (i % 3) != 0);
            step();
            if (i > 0) check("b2b_u0_fin", 64'(fin_o[0]), 64'd1);
        end
        idle(0);
        idle(1);
        step();
        check("b2b_u0_fin_last", 64'(fin_o[0]), 64'd1);
        repeat (4) step();

        // LAT=4: stall fills every stage before pushing back on issue
        put(1, 4'd0, 64'd100, 64'd1, 7'h30, 7'h30, 1'b1);
        step();
        wbst[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(1, 4'd4, 64'(i), 64'hFF, 7'(8'h31 + i), 7'(8'h31 + i), 1'b1);
            #1;
            check("t3_no_stall", 64'(stall_o[1]), 64'd0);
            step();
        end
        put(1, 4'd1, 64'd50, 64'd8, 7'h34, 7'h34, 1'b1);
        #1;
        check("t3_full_stall", 64'(stall_o[1]), 64'd1);
        check("t3_fin_held", 64'(fin_o[1]), 64'd1);
        step();
        wbst[1] = 1'b0;
        #1;
        check("t3_release", 64'(stall_o[1]), 64'd0);
        step();
        idle(1);
        repeat (7) step();

        // Squash: rob 3,4,5 in flight, boundary 4
        put(1, 4'd0, 64'd3, 64'd0, 7'h03, 7'h03, 1'b1);
        step();
        put(1, 4'd0, 64'd4, 64'd0, 7'h04, 7'h04, 1'b1);
        step();
        put(1, 4'd0, 64'd5, 64'd0, 7'h05, 7'h05, 1'b1);
        step();
        idle(1);
        step();
        check("t4_wwv_pre", 64'(wwv[1]), 64'd1);
        check("t4_wwprd_pre", 64'(wwprd[1]), 64'h05);
        put(1, 4'd0, 64'd6, 64'd0, 7'h06, 7'h06, 1'b1);
        sq[1]    = 1'b1;
        sqrob[1] = 7'h04;
        #1;
        check("t4_wwv_drop", 64'(wwv[1]), 64'd0);
        step();
        sq[1] = 1'b0;
        idle(1);
        repeat (6) step();

        // Squash of a stalled last stage
        put(0, 4'd3, 64'h1, 64'h2, 7'h0A, 7'h0A, 1'b1);
        step();
        idle(0);
        wbst[0] = 1'b1;
        step();
        check("t4_stalled_fin", 64'(fin_o[0]), 64'd1);
        sq[0]    = 1'b1;
        sqrob[0] = 7'h09;
        step();
        sq[0] = 1'b0;
        check("t4_stall_kill", 64'(fin_o[0]), 64'd0);
        wbst[0] = 1'b0;
        step();

        // Wrap-bit compare: boundary {1,3F}
        put(1, 4'd0, 64'd126, 64'd0, 7'h7E, 7'h7E, 1'b1);
        step();
        put(1, 4'd0, 64'd1, 64'd0, 7'h01, 7'h01, 1'b1);
        step();
        put(1, 4'd0, 64'd2, 64'd0, 7'h02, 7'h02, 1'b1);
        sq[1]    = 1'b1;
        sqrob[1] = 7'h7F;
        #1;
        check("t5_old_wwv", 64'(wwv[1]), 64'd1);
        check("t5_in_nostall", 64'(stall_o[1]), 64'd0);
        step();
        sq[1] = 1'b0;
        idle(1);
        repeat (6) step();

        // Reset with a full, stalled pipe
        wbst[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(1, 4'd4, 64'(i), 64'hFF, 7'(8'h40 + i), 7'(8'h40 + i), 1'b1);
            step();
        end
        put(1, 4'd0, 64'd9, 64'd9, 7'h44, 7'h44, 1'b1);
        #1;
        check("t6_full_stall", 64'(stall_o[1]), 64'd1);
        rst = 1'b1;
        idle(1);
        step();
        rst = 1'b0;
        wbst[1] = 1'b0;
        check("t6_rst_fin", 64'(fin_o[1]), 64'd0);
        check("t6_rst_stall", 64'(stall_o[1]), 64'd0);
        check("t6_rst_wwv", 64'(wwv[1]), 64'd0);
        put(1, 4'd0, 64'd20, 64'd22, 7'h50, 7'h50, 1'b1);
        step();
        idle(1);
        step();
        step();
        check("t6_fresh_early", 64'(fin_o[1]), 64'd0);
        step();
        check("t6_fresh_fin", 64'(fin_o[1]), 64'd1);
        check("t6_fresh_data", wbdata[1], 64'd42);
        repeat (3) step();

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
